// File: rtl/trng_pkg.sv
// trng_pkg: shared LFSR constants, arbiter state encoding and the LFSR step helper.
package trng_pkg;

    localparam int                LFSR_W    = 13;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h000F;

    typedef enum logic {
        HARVEST = 1'b0,
        READY   = 1'b1
    } arb_state_e;

    // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] r);
        return {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr13_core.sv
// lfsr13_core: 13-bit Fibonacci LFSR register with step enable and a load
// path that substitutes SEED for an all-zero value, so the register never locks up.
module lfsr13_core
    import trng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic              load_en,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] lfsr_out
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Load beats step; an all-zero load is replaced by the reset seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            lfsr_d = (load_val == '0) ? SEED : load_val;
        end else if (step_en) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/lfsr_word_arbiter.sv
// lfsr_word_arbiter: harvests a fresh LFSR word (SHIFTS_PER_WORD steps) and hands
// it to one requester at a time, round-robin, with a one-cycle one-hot grant.
module lfsr_word_arbiter
    import trng_pkg::*;
#(
    parameter int               NUM_REQ         = 4,
    parameter int               WIDTH           = LFSR_W,
    parameter int               SHIFTS_PER_WORD = 13,
    parameter logic [WIDTH-1:0] SEED            = LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   rnd_word,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_val,
    output logic               word_ready,
    output logic [15:0]        words_out
);

    localparam int CNT_W = 4;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  rnd_q, rnd_d;
    logic [15:0]       words_q, words_d;

    logic              step_en;
    logic [LFSR_W-1:0] lfsr;
    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    int                idx;

    lfsr13_core #(
        .SEED(LFSR_W'(SEED))
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .load_en (seed_load),
        .load_val(LFSR_W'(seed_val)),
        .lfsr_out(lfsr)
    );

    // Round-robin pick: first active request at or above the pointer, wrapping;
    // suppressed outside READY and whenever a seed load is in progress.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        if (state_q == READY && !seed_load) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!gnt_found && req[idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(idx);
                end
            end
        end
    end

    // FSM next state: seed load restarts harvesting, HARVEST counts shifts,
    // READY waits for a request and delivers the frozen word on grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rnd_d   = rnd_q;
        words_d = words_q;
        step_en = 1'b0;
        if (seed_load) begin
            state_d = HARVEST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HARVEST: begin
                    step_en = 1'b1;
                    if (cnt_q == CNT_W'(SHIFTS_PER_WORD - 1)) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (gnt_found) begin
                        rnd_d   = WIDTH'(lfsr);
                        words_d = words_q + 16'd1;
                        ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state_d = HARVEST;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = HARVEST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters, round-robin pointer and delivered-word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HARVEST;
            cnt_q   <= '0;
            ptr_q   <= '0;
            rnd_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            rnd_q   <= rnd_d;
            words_q <= words_d;
        end
    end

    // The word is visible in its grant cycle, then held in rnd_q until the next grant.
    assign gnt        = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rnd_word   = gnt_found ? WIDTH'(lfsr) : rnd_q;
    assign word_ready = (state_q == READY);
    assign words_out  = words_q;

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// tb_lfsr_word_arbiter: vector table, directed corner cases and random traffic,
// all checked against a behavioural word-delivery model.
module tb_lfsr_word_arbiter;

    localparam int          NUM_REQ = 4;
    localparam int          WIDTH   = 13;
    localparam int          SPW     = 13;
    localparam logic [12:0] SEED    = 13'h000F;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic               seed_load = 1'b0;
    logic [WIDTH-1:0]   seed_val = '0;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   rnd_word;
    logic               word_ready;
    logic [15:0]        words_out;

    int total = 0;
    int bad   = 0;

    // behavioural model: current LFSR word, shifts still owed, rr pointer, counters
    logic [12:0] m_lfsr;
    int          m_left;
    int          m_ptr;
    int          m_words;
    logic [12:0] m_last;

    // values seen on the DUT at the last sample point
    logic [NUM_REQ-1:0] obs_gnt;
    logic [WIDTH-1:0]   obs_rnd;
    logic               obs_ready;
    logic [15:0]        obs_words;

    typedef struct {
        int          holdCycles;
        logic [3:0]  req;
        logic [3:0]  expGnt;
        logic [12:0] expRnd;
        logic        checkRnd;
        logic        expReady;
        logic [15:0] expWords;
    } vec_t;

    vec_t vecs[8];

    lfsr_word_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH(WIDTH),
        .SHIFTS_PER_WORD(SPW),
        .SEED(SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .rnd_word  (rnd_word),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .word_ready(word_ready),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [12:0] specStep(input logic [12:0] r);
        return {r[11:0], r[12] ^ r[3] ^ r[2] ^ r[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_lfsr  = SEED;
        m_left  = SPW;
        m_ptr   = 0;
        m_words = 0;
        m_last  = '0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, " rnd_word"}, 32'(rnd_word), 32'd0);
        checkOutput({tag, " word_ready"}, 32'(word_ready), 32'd0);
        checkOutput({tag, " words_out"}, 32'(words_out), 32'd0);
    endtask

    // Entered at a falling edge: drive, sample, compare with the model, advance
    // the model over the coming rising edge, and return at the next falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic sl, input logic [12:0] sv);
        logic [3:0]  expGnt;
        logic [12:0] expRnd;
        logic        expReady;
        int          expIdx;
        req       = r;
        seed_load = sl;
        seed_val  = sv;
        #1;
        expReady = (m_left == 0);
        expIdx   = -1;
        expGnt   = '0;
        if (expReady && !sl) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (expIdx < 0 && r[i]) expIdx = i;
            end
        end
        if (expIdx >= 0) expGnt[expIdx] = 1'b1;
        expRnd = (expIdx >= 0) ? m_lfsr : m_last;
        obs_gnt   = gnt;
        obs_rnd   = rnd_word;
        obs_ready = word_ready;
        obs_words = words_out;
        checkOutput("model gnt", 32'(obs_gnt), 32'(expGnt));
        checkOutput("model rnd_word", 32'(obs_rnd), 32'(expRnd));
        checkOutput("model word_ready", 32'(obs_ready), 32'(expReady));
        checkOutput("model words_out", 32'(obs_words), 32'(m_words));
        if (sl) begin
            m_lfsr = (sv == 13'd0) ? SEED : sv;
            m_left = SPW;
        end else if (m_left > 0) begin
            m_lfsr = specStep(m_lfsr);
            m_left--;
        end else if (expIdx >= 0) begin
            m_last  = m_lfsr;
            m_words = (m_words + 1) % 65536;
            m_ptr   = (expIdx + 1) % NUM_REQ;
            m_left  = SPW;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req       = '0;
        seed_load = 1'b0;
        seed_val  = '0;
        #1;
        checkResetValues("reset");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Idle until word_ready, bounded; an expired bound counts as a failure.
    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (m_left != 0 && n < 40) begin
            applyStimulus(4'b0000, 1'b0, 13'd0);
            n++;
        end
        checkOutput({tag, " reached READY"}, 32'(m_left == 0), 32'd1);
    endtask

    initial begin
        int gntCycle[5];
        logic [3:0] gntVec[5];
        int nGnt;
        int cyc;
        int n;
        logic sawGnt;

        vecs[0] = '{13, 4'b0000, 4'b0000, 13'h0000, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{1,  4'b0000, 4'b0000, 13'h0000, 1'b1, 1'b1, 16'd0};
        vecs[2] = '{3,  4'b0000, 4'b0000, 13'h0000, 1'b1, 1'b1, 16'd0};
        vecs[3] = '{1,  4'b0001, 4'b0001, 13'h1FF4, 1'b1, 1'b1, 16'd0};
        vecs[4] = '{1,  4'b0001, 4'b0000, 13'h1FF4, 1'b1, 1'b0, 16'd1};
        vecs[5] = '{12, 4'b0001, 4'b0000, 13'h1FF4, 1'b1, 1'b0, 16'd1};
        vecs[6] = '{1,  4'b0001, 4'b0001, 13'h0000, 1'b0, 1'b1, 16'd1};
        vecs[7] = '{1,  4'b0000, 4'b0000, 13'h0000, 1'b0, 1'b0, 16'd2};

        @(negedge clk);
        doReset();

        // vector table: first harvest, first grant, 14-cycle spacing
        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < vecs[v].holdCycles; c++) begin
                applyStimulus(vecs[v].req, 1'b0, 13'd0);
            end
            checkOutput($sformatf("vec%0d gnt", v), 32'(obs_gnt), 32'(vecs[v].expGnt));
            checkOutput($sformatf("vec%0d word_ready", v), 32'(obs_ready), 32'(vecs[v].expReady));
            checkOutput($sformatf("vec%0d words_out", v), 32'(obs_words), 32'(vecs[v].expWords));
            if (vecs[v].checkRnd) begin
                checkOutput($sformatf("vec%0d rnd_word", v), 32'(obs_rnd), 32'(vecs[v].expRnd));
            end
        end

        // all requesters held: rotation 0,1,2,3,0 at 14-cycle spacing from reset
        doReset();
        nGnt = 0;
        cyc  = 0;
        while (nGnt < 5 && cyc < 100) begin
            applyStimulus(4'b1111, 1'b0, 13'd0);
            if (obs_gnt != '0) begin
                gntCycle[nGnt] = cyc;
                gntVec[nGnt]   = obs_gnt;
                nGnt++;
            end
            cyc++;
        end
        checkOutput("rr grant count", 32'(nGnt), 32'd5);
        for (int g = 0; g < nGnt; g++) begin
            checkOutput($sformatf("rr grant%0d vector", g), 32'(gntVec[g]), 32'(4'b0001 << (g % 4)));
            checkOutput($sformatf("rr grant%0d cycle", g), 32'(gntCycle[g]), 32'(13 + 14 * g));
        end

        // seed_load of zero in READY with a pending request: load wins
        waitReady("seedload");
        applyStimulus(4'b0010, 1'b1, 13'd0);
        checkOutput("seedload blocks gnt", 32'(obs_gnt), 32'd0);
        n = 0;
        sawGnt = 1'b0;
        while (!sawGnt && n < 30) begin
            applyStimulus(4'b0010, 1'b0, 13'd0);
            n++;
            sawGnt = (obs_gnt != '0);
        end
        checkOutput("seedload grant latency", 32'(n), 32'd14);
        checkOutput("seedload grant vector", 32'(obs_gnt), 32'(4'b0010));
        checkOutput("seedload rnd_word", 32'(obs_rnd), 32'h1FF4);

        // request pulsed during harvest and dropped: forfeited, word stays ready
        for (int c = 0; c < 3; c++) applyStimulus(4'b0100, 1'b0, 13'd0);
        sawGnt = 1'b0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'b0000, 1'b0, 13'd0);
            if (obs_gnt != '0) sawGnt = 1'b1;
        end
        checkOutput("dropped req no gnt", 32'(sawGnt), 32'd0);
        checkOutput("dropped req word_ready", 32'(obs_ready), 32'd1);

        // reset at harvest cycle 6
        doReset();
        for (int c = 0; c < 6; c++) applyStimulus(4'b0000, 1'b0, 13'd0);
        req = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("midharvest rst");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 13; c++) applyStimulus(4'b0001, 1'b0, 13'd0);
        applyStimulus(4'b0001, 1'b0, 13'd0);
        checkOutput("post-rst first gnt", 32'(obs_gnt), 32'(4'b0001));
        checkOutput("post-rst first word", 32'(obs_rnd), 32'h1FF4);

        // reset while a grant is being presented: gnt drops asynchronously
        waitReady("grant rst");
        req = 4'b1000;
        #1;
        checkOutput("grant rst gnt before", 32'(gnt), 32'(4'b1000));
        rst = 1'b1;
        #1;
        checkResetValues("grant rst");
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        // words_out wrap from 16'hFFFF to 0
        waitReady("wrap");
        force dut.words_q = 16'hFFFF;
        #1;
        release dut.words_q;
        m_words = 16'hFFFF;
        checkOutput("wrap preset", 32'(words_out), 32'hFFFF);
        applyStimulus(4'b0100, 1'b0, 13'd0);
        checkOutput("wrap gnt", 32'(obs_gnt), 32'(4'b0100));
        applyStimulus(4'b0000, 1'b0, 13'd0);
        checkOutput("wrap words_out", 32'(obs_words), 32'd0);

        // random traffic with occasional seed loads (some all-zero)
        doReset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0]  r;
            logic        sl;
            logic [12:0] sv;
            r  = 4'($urandom_range(0, 15));
            sl = ($urandom_range(0, 39) == 0);
            sv = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom);
            applyStimulus(r, sl, sv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
